window_stream_gen: RTL and testbench

- Streaming K x K sliding-window generator for the CNN conv front end; successor to the fixed 3x3, 28-wide line-buffer controller.
- Accepts a raster-scan multi-channel pixel stream and emits one packed K x K x C window per valid output position.
- Supports configurable kernel size, stride, frame size and channel count, with valid/ready backpressure on both sides.
- Sits between the image/feature-map source and the conv MAC array; also used between conv layers.

---
 rtl/window_stream_gen.sv | 145 ++++++++++++++
 tb/tb_window_stream_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/window_stream_gen.sv
// Streaming K x K x C sliding-window generator over a raster-scan pixel stream.
// Uses K-1 line buffers and a column-shifting window register that also serves as the output holding register.
module window_stream_gen #(
    parameter int W = 28,
    parameter int H = 28,
    parameter int B = 8,
    parameter int C = 1,
    parameter int K = 3,
    parameter int S = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [C*B-1:0]       i_pixel_data,
    input  logic                 i_pixel_data_valid,
    output logic                 o_pixel_ready,
    output logic [K*K*C*B-1:0]   o_win_data,
    output logic                 o_win_valid,
    input  logic                 i_win_ready,
    output logic                 o_win_last,
    output logic                 o_frame_done
);
    localparam int PW       = C * B;
    localparam int CW       = $clog2(W);
    localparam int RW       = $clog2(H);
    localparam int SW       = (S > 1) ? $clog2(S) : 1;
    localparam int ROW_LAST = K - 1 + ((H - K) / S) * S;
    localparam int COL_LAST = K - 1 + ((W - K) / S) * S;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [SW-1:0] col_ph;
    logic [SW-1:0] row_ph;

    logic [PW-1:0] line_buf [K-1][W];
    logic [PW-1:0] buf_in   [K-1];
    logic [PW-1:0] new_col  [K];
    logic [PW-1:0] win      [K][K];

    logic accept;
    logic col_end;
    logic row_end;
    logic win_hit;
    logic last_hit;

    assign o_pixel_ready = !o_win_valid || i_win_ready;
    assign accept        = i_pixel_data_valid && o_pixel_ready;
    assign col_end       = (col == CW'(W - 1));
    assign row_end       = (row == RW'(H - 1));
    // Phases are zero exactly on stride-aligned positions once the kernel fits.
    assign win_hit       = (row >= RW'(K - 1)) && (col >= CW'(K - 1)) &&
                           (row_ph == '0) && (col_ph == '0);
    assign last_hit      = (row == RW'(ROW_LAST)) && (col == CW'(COL_LAST));

    always_comb begin
        buf_in[0] = i_pixel_data;
        for (int k = 1; k < K - 1; k++) begin
            buf_in[k] = line_buf[k-1][W-1];
        end
    end

    // Buffer k tail holds the pixel k+1 rows above the incoming one; index 0 of new_col is the oldest row.
    always_comb begin
        for (int i = 0; i < K - 1; i++) begin
            new_col[i] = line_buf[K-2-i][W-1];
        end
        new_col[K-1] = i_pixel_data;
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            for (int k = 0; k < K - 1; k++) begin
                line_buf[k][0] <= buf_in[k];
                for (int x = 1; x < W; x++) begin
                    line_buf[k][x] <= line_buf[k][x-1];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            col          <= '0;
            row          <= '0;
            col_ph       <= '0;
            row_ph       <= '0;
            o_win_valid  <= 1'b0;
            o_win_last   <= 1'b0;
            o_frame_done <= 1'b0;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else begin
            o_frame_done <= accept && col_end && row_end;

            // Accept only happens when the output slot is free or draining, so shifting never disturbs a held window.
            if (accept) begin
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K - 1; j++) begin
                        win[i][j] <= win[i][j+1];
                    end
                    win[i][K-1] <= new_col[i];
                end

                if (col_end) begin
                    col    <= '0;
                    col_ph <= '0;
                    if (row_end) begin
                        row    <= '0;
                        row_ph <= '0;
                    end else begin
                        row <= row + RW'(1);
                        if (row >= RW'(K - 1)) begin
                            row_ph <= (row_ph == SW'(S - 1)) ? '0 : row_ph + SW'(1);
                        end
                    end
                end else begin
                    col <= col + CW'(1);
                    if (col >= CW'(K - 1)) begin
                        col_ph <= (col_ph == SW'(S - 1)) ? '0 : col_ph + SW'(1);
                    end
                end
            end

            if (accept && win_hit) begin
                o_win_valid <= 1'b1;
                o_win_last  <= last_hit;
            end else if (i_win_ready) begin
                o_win_valid <= 1'b0;
                o_win_last  <= 1'b0;
            end
        end
    end

    always_comb begin
        o_win_data = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                o_win_data[((i*K+j)*PW) +: PW] = win[i][j];
            end
        end
    end

endmodule

// File: tb/tb_window_stream_gen.sv
// Bench for window_stream_gen: several geometries run side by side, each against a frame-array reference model.
module tb_window_stream_gen;
    localparam int B    = 8;
    localparam int DMAX = 600;
    localparam int CFG_W [4] = '{5, 5, 7, 8};
    localparam int CFG_H [4] = '{5, 5, 7, 6};
    localparam int CFG_K [4] = '{3, 3, 5, 3};
    localparam int CFG_S [4] = '{1, 2, 1, 2};
    localparam int CFG_C [4] = '{1, 1, 3, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [DMAX-1:0] obs, input logic [DMAX-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g
            localparam int GW   = CFG_W[gi];
            localparam int GH   = CFG_H[gi];
            localparam int GK   = CFG_K[gi];
            localparam int GS   = CFG_S[gi];
            localparam int GC   = CFG_C[gi];
            localparam int PWD  = GC * B;
            localparam int DW   = GK * GK * PWD;
            localparam int NPIX = GW * GH;
            localparam int NWIN = ((GH - GK) / GS + 1) * ((GW - GK) / GS + 1);
            localparam int RL   = GK - 1 + ((GH - GK) / GS) * GS;
            localparam int CL   = GK - 1 + ((GW - GK) / GS) * GS;

            logic           rst = 1'b1;
            logic           pv  = 1'b0;
            logic           wr  = 1'b0;
            logic [PWD-1:0] px  = '0;
            logic           pready, wv, wlast, fd;
            logic [DW-1:0]  wdata;

            window_stream_gen #(.W(GW), .H(GH), .B(B), .C(GC), .K(GK), .S(GS)) dut (
                .i_clk              (clk),
                .i_rst              (rst),
                .i_pixel_data       (px),
                .i_pixel_data_valid (pv),
                .o_pixel_ready      (pready),
                .o_win_data         (wdata),
                .o_win_valid        (wv),
                .i_win_ready        (wr),
                .o_win_last         (wlast),
                .o_frame_done       (fd)
            );

            logic [PWD-1:0] frame [NPIX];
            bit             m_valid = 1'b0;
            bit             m_last  = 1'b0;
            bit             m_fd    = 1'b0;
            logic [DW-1:0]  m_data  = '0;
            int             idx = 0;
            int             nfr = 0;
            int             nhs = 0;
            bit             done = 1'b0;

            function automatic logic [PWD-1:0] seq_pix(input int p);
                logic [PWD-1:0] v;
                for (int c = 0; c < GC; c++) v[c*B +: B] = B'(p + c);
                return v;
            endfunction

            function automatic logic [PWD-1:0] rnd_pix();
                logic [PWD-1:0] v;
                for (int c = 0; c < GC; c++) v[c*B +: B] = B'($urandom);
                return v;
            endfunction

            // One clock: apply inputs, check ready, advance the reference, check registered outputs.
            task automatic cyc(input bit v, input logic [PWD-1:0] p, input bit r);
                bit acc, nv, nl, nf;
                logic [DW-1:0] nd;
                int rr, cc;
                pv = v; px = p; wr = r;
                #1;
                chk($sformatf("c%0d pixel_ready", gi), DMAX'(pready), DMAX'(!m_valid || r));
                if (wv && r) nhs++;
                acc = v && (!m_valid || r);
                nv = m_valid && !r;
                nl = m_last;
                nd = m_data;
                nf = 1'b0;
                if (acc) begin
                    rr = idx / GW;
                    cc = idx % GW;
                    frame[idx] = p;
                    if (rr >= GK - 1 && cc >= GK - 1 &&
                        (rr - GK + 1) % GS == 0 && (cc - GK + 1) % GS == 0) begin
                        nv = 1'b1;
                        nl = (rr == RL) && (cc == CL);
                        for (int i = 0; i < GK; i++)
                            for (int j = 0; j < GK; j++)
                                nd[((i*GK+j)*PWD) +: PWD] = frame[(rr-GK+1+i)*GW + (cc-GK+1+j)];
                    end
                    nf  = (idx == NPIX - 1);
                    idx = (idx + 1) % NPIX;
                end
                @(posedge clk);
                #1;
                m_valid = nv; m_last = nl; m_data = nd; m_fd = nf;
                if (nf) nfr++;
                chk($sformatf("c%0d win_valid", gi), DMAX'(wv), DMAX'(m_valid));
                if (m_valid) begin
                    chk($sformatf("c%0d win_data", gi), DMAX'(wdata), DMAX'(m_data));
                    chk($sformatf("c%0d win_last", gi), DMAX'(wlast), DMAX'(m_last));
                end
                chk($sformatf("c%0d frame_done", gi), DMAX'(fd), DMAX'(m_fd));
            endtask

            task automatic drain();
                for (int n = 0; n < 4 && m_valid; n++) cyc(1'b0, '0, 1'b1);
            endtask

            initial begin
                int target;
                int guard;
                #1;
                chk($sformatf("c%0d rst_valid", gi), DMAX'(wv), DMAX'(0));
                chk($sformatf("c%0d rst_last", gi), DMAX'(wlast), DMAX'(0));
                chk($sformatf("c%0d rst_done", gi), DMAX'(fd), DMAX'(0));
                chk($sformatf("c%0d rst_data", gi), DMAX'(wdata), DMAX'(0));
                chk($sformatf("c%0d rst_ready", gi), DMAX'(pready), DMAX'(1));
                @(posedge clk);
                #1 rst = 1'b0;

                for (int p = 0; p < NPIX; p++) cyc(1'b1, seq_pix(p), 1'b1);

                // Random valid/ready gaps over back-to-back frames of random pixels.
                target = nfr + 3;
                for (guard = 0; guard < 20000 && nfr < target; guard++)
                    cyc($urandom_range(0, 3) != 0, rnd_pix(), $urandom_range(0, 2) != 0);
                chk($sformatf("c%0d frames", gi), DMAX'(nfr), DMAX'(4));
                drain();
                chk($sformatf("c%0d win_count", gi), DMAX'(nhs), DMAX'(4 * NWIN));
                nhs = 0;

                // Park a window with the consumer stalled, then reset asynchronously.
                for (int p = 0; p < GW * GK + 1; p++) cyc(1'b1, seq_pix(p), 1'b1);
                for (int n = 0; n < 50 && !m_valid; n++) cyc(1'b1, seq_pix(GW * GK + 1 + n), 1'b0);
                for (int n = 0; n < 3; n++) cyc(1'b1, seq_pix(200 + n), 1'b0);
                pv = 1'b0;
                #1 rst = 1'b1;
                #1;
                chk($sformatf("c%0d arst_valid", gi), DMAX'(wv), DMAX'(0));
                chk($sformatf("c%0d arst_data", gi), DMAX'(wdata), DMAX'(0));
                m_valid = 1'b0; m_last = 1'b0; m_fd = 1'b0; idx = 0; nhs = 0;
                @(posedge clk);
                #1 rst = 1'b0;

                for (int p = 0; p < NPIX; p++) cyc(1'b1, seq_pix(100 + p), 1'b1);
                drain();
                chk($sformatf("c%0d win_count_post", gi), DMAX'(nhs), DMAX'(NWIN));
                chk($sformatf("c%0d frames_post", gi), DMAX'(nfr), DMAX'(5));
                done = 1'b1;
            end
        end
    endgenerate

    initial begin
        bit all_done;
        all_done = 1'b0;
        for (int t = 0; t < 60000 && !all_done; t++) begin
            @(posedge clk);
            all_done = g[0].done && g[1].done && g[2].done && g[3].done;
        end
        chk("all_done", DMAX'(all_done), DMAX'(1));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
